// File: rtl/xadc_drp_reader.sv
// Turns each XADC end-of-sequence event into two DRP reads (current, then
// voltage) and presents the pair as one sample on a valid/ready output.
module xadc_drp_reader #(
  parameter logic [6:0]  CURRENT_ADDR = 7'h14,
  parameter logic [6:0]  VOLTAGE_ADDR = 7'h1C,
  parameter int unsigned DRDY_TIMEOUT = 64
) (
  input  logic        dclk_in,
  input  logic        reset_in,
  input  logic        eos_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  output logic [6:0]  daddr_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        sample_valid_out,
  input  logic        sample_ready_in,
  output logic [11:0] current_sample_out,
  output logic [11:0] voltage_sample_out,
  output logic [15:0] overrun_count_out,
  output logic        timeout_out
);

  typedef enum logic [2:0] {
    IDLE,
    CUR_REQ,
    CUR_WAIT,
    VOLT_REQ,
    VOLT_WAIT,
    PUBLISH
  } state_t;

  // The last waiting cycle is still allowed to accept drdy_in.
  localparam logic [7:0] WAIT_LAST = 8'(DRDY_TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic [11:0] cur_hold, volt_hold;
  logic        in_wait, wait_expired;
  logic        cur_capture, volt_capture, timeout_hit, publish;
  logic        eos_busy, overwrite;
  logic [16:0] overrun_sum;
  logic        unused_do_bits;

  assign dwe_out        = 1'b0;
  assign di_out         = '0;
  assign unused_do_bits = ^do_in[3:0];

  assign in_wait      = (state == CUR_WAIT) || (state == VOLT_WAIT);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge dclk_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: a default assignment before the case keeps this purely
  // combinational; a path that leaves next_state unassigned infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (eos_in) next_state = CUR_REQ;
      CUR_REQ:   next_state = CUR_WAIT;
      CUR_WAIT:  if (drdy_in) next_state = VOLT_REQ;
                 else if (wait_expired) next_state = IDLE;
      VOLT_REQ:  next_state = VOLT_WAIT;
      VOLT_WAIT: if (drdy_in) next_state = PUBLISH;
                 else if (wait_expired) next_state = IDLE;
      PUBLISH:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    den_out      = (state == CUR_REQ) || (state == VOLT_REQ);
    cur_capture  = (state == CUR_WAIT) && drdy_in;
    volt_capture = (state == VOLT_WAIT) && drdy_in;
    timeout_hit  = in_wait && !drdy_in && wait_expired;
    publish      = (state == PUBLISH);
  end

  // Two overrun sources can coincide: an eos during PUBLISH that also overwrites.
  assign eos_busy    = eos_in && (state != IDLE);
  assign overwrite   = publish && sample_valid_out && !sample_ready_in;
  assign overrun_sum = {1'b0, overrun_count_out} + 17'(eos_busy) + 17'(overwrite);

  // NOTE: the holding registers are reset along with everything else so a
  // reset mid-read can never leak a stale half-pair into a later publish.
  always_ff @(posedge dclk_in or negedge reset_in) begin
    if (!reset_in) begin
      wait_cnt           <= '0;
      daddr_out          <= '0;
      cur_hold           <= '0;
      volt_hold          <= '0;
      sample_valid_out   <= 1'b0;
      current_sample_out <= '0;
      voltage_sample_out <= '0;
      overrun_count_out  <= '0;
      timeout_out        <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + 8'd1 : 8'd0;

      if ((state == IDLE) && eos_in) daddr_out <= CURRENT_ADDR;
      else if (cur_capture)          daddr_out <= VOLTAGE_ADDR;

      if (cur_capture)  cur_hold  <= do_in[15:4];
      if (volt_capture) volt_hold <= do_in[15:4];

      if (publish) begin
        sample_valid_out   <= 1'b1;
        current_sample_out <= cur_hold;
        voltage_sample_out <= volt_hold;
      end else if (sample_ready_in) begin
        sample_valid_out <= 1'b0;
      end

      overrun_count_out <= overrun_sum[16] ? 16'hFFFF : overrun_sum[15:0];

      if (timeout_hit) timeout_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Directed bench for xadc_drp_reader: a DRP responder, a timestamp-based
// transaction model checked every cycle, and literal checks per scenario.
module tb_xadc_drp_reader;

  localparam logic [6:0] CUR_A  = 7'h14;
  localparam logic [6:0] VOLT_A = 7'h1C;
  localparam int         T      = 64;

  logic        dclk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        eos_in = 1'b0;
  logic        den_out, dwe_out;
  logic [15:0] di_out;
  logic [6:0]  daddr_out;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = 16'h5A5F;
  logic        sample_valid_out;
  logic        sample_ready_in = 1'b0;
  logic [11:0] current_sample_out, voltage_sample_out;
  logic [15:0] overrun_count_out;
  logic        timeout_out;

  xadc_drp_reader #(.CURRENT_ADDR(CUR_A), .VOLTAGE_ADDR(VOLT_A), .DRDY_TIMEOUT(T)) dut (
    .dclk_in(dclk_in), .reset_in(reset_in), .eos_in(eos_in),
    .den_out(den_out), .dwe_out(dwe_out), .di_out(di_out), .daddr_out(daddr_out),
    .drdy_in(drdy_in), .do_in(do_in),
    .sample_valid_out(sample_valid_out), .sample_ready_in(sample_ready_in),
    .current_sample_out(current_sample_out), .voltage_sample_out(voltage_sample_out),
    .overrun_count_out(overrun_count_out), .timeout_out(timeout_out)
  );

  always #5 dclk_in = ~dclk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DRP responder: answers a den with drdy bfm_delay cycles later (<0: never).
  int          bfm_delay = 1;
  logic [15:0] bfm_cur = '0, bfm_volt = '0;
  int          resp_cyc = -1;
  logic [6:0]  resp_addr = '0;

  // Model: a read job is described by timestamps (den cycle, wait window,
  // publish cycle) rather than by a state machine.
  bit          m_busy, m_second;
  int          m_den_cyc, m_win_lo, m_win_hi, m_pub_cyc;
  logic [11:0] h_cur, h_volt;
  logic        e_valid, e_to;
  logic [11:0] e_cur, e_volt;
  int          e_ovr;
  logic [6:0]  e_addr;

  task automatic model_reset();
    m_busy = 0; m_second = 0;
    m_den_cyc = -1; m_win_lo = 0; m_win_hi = -1; m_pub_cyc = -1;
    h_cur = '0; h_volt = '0;
    e_valid = 0; e_to = 0; e_cur = '0; e_volt = '0; e_ovr = 0; e_addr = '0;
  endtask

  task automatic model_step(int n);
    bit was_busy, pub_now;
    int inc;
    if (!reset_in) begin
      model_reset();
      return;
    end
    was_busy = m_busy;
    pub_now  = m_busy && (n == m_pub_cyc);
    inc = 0;
    if (eos_in && was_busy) inc++;
    if (pub_now && e_valid && !sample_ready_in) inc++;
    e_ovr = (e_ovr + inc > 65535) ? 65535 : e_ovr + inc;
    if (pub_now) begin
      e_valid = 1; e_cur = h_cur; e_volt = h_volt; m_busy = 0;
    end else if (sample_ready_in) begin
      e_valid = 0;
    end
    if (was_busy && !pub_now && n >= m_win_lo && n <= m_win_hi) begin
      if (drdy_in) begin
        if (!m_second) begin
          h_cur = do_in[15:4]; m_second = 1; e_addr = VOLT_A;
          m_den_cyc = n + 1; m_win_lo = n + 2; m_win_hi = n + 1 + T;
        end else begin
          h_volt = do_in[15:4]; m_pub_cyc = n + 1; m_win_hi = -1;
        end
      end else if (n == m_win_hi) begin
        e_to = 1; m_busy = 0;
      end
    end
    if (!was_busy && eos_in) begin
      m_busy = 1; m_second = 0; m_pub_cyc = -1; e_addr = CUR_A;
      m_den_cyc = n + 1; m_win_lo = n + 2; m_win_hi = n + 1 + T;
    end
  endtask

  int cyc = 0;
  int den_count = 0;
  int xfers = 0;
  logic [6:0]  den_addrs[$];
  logic [23:0] xq[$];

  task automatic compare();
    check("den", den_out, m_busy && (cyc == m_den_cyc));
    check("daddr", daddr_out, e_addr);
    check("valid", sample_valid_out, e_valid);
    check("cur", current_sample_out, e_cur);
    check("volt", voltage_sample_out, e_volt);
    check("overrun", overrun_count_out, e_ovr[15:0]);
    check("timeout", timeout_out, e_to);
    check("dwe_di", {dwe_out, di_out}, 17'h0);
  endtask

  task automatic tick();
    if (sample_valid_out && sample_ready_in) begin
      xfers++;
      xq.push_back({current_sample_out, voltage_sample_out});
    end
    @(posedge dclk_in);
    model_step(cyc);
    cyc++;
    #1;
    compare();
    if (den_out) begin
      den_count++;
      den_addrs.push_back(daddr_out);
      resp_cyc  = (bfm_delay >= 0) ? cyc + bfm_delay : -1;
      resp_addr = daddr_out;
    end
    drdy_in = (cyc == resp_cyc);
    do_in   = drdy_in ? ((resp_addr == CUR_A) ? bfm_cur : bfm_volt) : 16'h5A5F;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_eos();
    eos_in = 1'b1;
    tick();
    eos_in = 1'b0;
  endtask

  int d0, x0;

  initial begin
    model_reset();
    ticks(3);
    check("rst_outputs", {sample_valid_out, den_out, daddr_out, overrun_count_out, timeout_out}, 0);
    check("rst_samples", {current_sample_out, voltage_sample_out}, 0);
    reset_in = 1'b1;
    ticks(2);

    // Basic read: valid 6 cycles after eos.
    bfm_delay = 1; bfm_cur = 16'hABC0; bfm_volt = 16'h1230;
    den_addrs.delete(); d0 = den_count;
    pulse_eos();
    ticks(4);
    check("basic_not_yet", sample_valid_out, 1'b0);
    tick();
    check("basic_valid_lat6", sample_valid_out, 1'b1);
    check("basic_cur", current_sample_out, 12'hABC);
    check("basic_volt", voltage_sample_out, 12'h123);
    check("basic_den_cnt", den_count - d0, 2);
    check("basic_addr0", den_addrs[0], 7'h14);
    check("basic_addr1", den_addrs[1], 7'h1C);
    check("basic_overrun", overrun_count_out, 16'd0);
    sample_ready_in = 1'b1;
    tick();
    sample_ready_in = 1'b0;
    check("basic_valid_clear", sample_valid_out, 1'b0);

    // Backpressure overwrite.
    bfm_cur = 16'h1110; bfm_volt = 16'h2220;
    pulse_eos();
    ticks(19);
    bfm_cur = 16'h3330; bfm_volt = 16'h4440;
    pulse_eos();
    ticks(10);
    check("bp_valid", sample_valid_out, 1'b1);
    check("bp_pair", {current_sample_out, voltage_sample_out}, 24'h333444);
    check("bp_overrun", overrun_count_out, 16'd1);
    x0 = xfers;
    sample_ready_in = 1'b1;
    ticks(3);
    sample_ready_in = 1'b0;
    check("bp_one_xfer", xfers - x0, 1);
    check("bp_xfer_data", xq[$], 24'h333444);

    // Accept on the exact PUBLISH cycle.
    bfm_cur = 16'h5550; bfm_volt = 16'h6660;
    pulse_eos();
    ticks(7);
    check("sim_a_valid", sample_valid_out, 1'b1);
    bfm_cur = 16'h7770; bfm_volt = 16'h8880;
    pulse_eos();
    ticks(4);
    sample_ready_in = 1'b1;
    tick();
    sample_ready_in = 1'b0;
    check("sim_a_xfer", xq[$], 24'h555666);
    check("sim_b_valid", sample_valid_out, 1'b1);
    check("sim_b_pair", {current_sample_out, voltage_sample_out}, 24'h777888);
    check("sim_overrun", overrun_count_out, 16'd1);
    sample_ready_in = 1'b1;
    tick();
    check("sim_b_xfer", xq[$], 24'h777888);

    // eos while busy: ignored, counted.
    bfm_delay = 10; bfm_cur = 16'h9990; bfm_volt = 16'hAAA0;
    d0 = den_count; x0 = xfers;
    pulse_eos();
    ticks(2);
    pulse_eos();
    ticks(26);
    check("busy_den_cnt", den_count - d0, 2);
    check("busy_one_pub", xfers - x0, 1);
    check("busy_pair", xq[$], 24'h999AAA);
    check("busy_overrun", overrun_count_out, 16'd2);

    // drdy on the final counted cycle still wins.
    bfm_delay = T; bfm_cur = 16'h0FF0; bfm_volt = 16'hF000;
    x0 = xfers;
    pulse_eos();
    ticks(140);
    check("edge_no_timeout", timeout_out, 1'b0);
    check("edge_pub", xfers - x0, 1);
    check("edge_pair", xq[$], 24'h0FFF00);

    // Timeout: drdy never comes.
    bfm_delay = -1;
    x0 = xfers;
    pulse_eos();
    ticks(64);
    check("to_not_yet", timeout_out, 1'b0);
    tick();
    check("to_set", timeout_out, 1'b1);
    check("to_no_valid", sample_valid_out, 1'b0);
    ticks(3);
    bfm_delay = 1; bfm_cur = 16'h0120; bfm_volt = 16'h0340;
    pulse_eos();
    ticks(9);
    check("to_recover_pub", xfers - x0, 1);
    check("to_recover_pair", xq[$], 24'h012034);
    check("to_sticky", timeout_out, 1'b1);

    // Reset during VOLT_WAIT, late drdy after release.
    bfm_delay = 5; bfm_cur = 16'hCDE0; bfm_volt = 16'hF010;
    pulse_eos();
    ticks(8);
    reset_in = 1'b0;
    ticks(2);
    reset_in = 1'b1;
    check("rmid_clear", {sample_valid_out, den_out, daddr_out, overrun_count_out, timeout_out}, 0);
    check("rmid_samples", {current_sample_out, voltage_sample_out}, 0);
    x0 = xfers;
    ticks(10);
    check("rmid_no_pub", xfers - x0, 0);
    bfm_delay = 1; bfm_cur = 16'h4560; bfm_volt = 16'h7890;
    pulse_eos();
    ticks(9);
    check("rmid_next_pub", xfers - x0, 1);
    check("rmid_next_pair", xq[$], 24'h456789);
    check("rmid_overrun", overrun_count_out, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
